// File: rtl/elastic_shift_fifo_pkg.sv
// Shared constants and helpers for the elastic shift FIFO slice.
package elastic_pkg;

  localparam int SAT_MODE_TRUNC = 0;
  localparam int SAT_MODE_SAT   = 1;

  // Address width that never collapses to zero bits, so a pointer always
  // has at least one index bit plus the wrap bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/elastic_shift_fifo_shifter.sv
// Combinational left shifter with optional saturation on lost high bits.
module elastic_shifter
  import elastic_pkg::*;
#(
  parameter int DATA_W = 32,
  localparam int SH_W  = $clog2(DATA_W)
) (
  input  logic [DATA_W-1:0] data_i,
  input  logic [SH_W-1:0]   shamt_i,
  input  logic              mode_i,
  output logic [DATA_W-1:0] result_o,
  output logic              sat_o
);

  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] lostMask;
  logic              overflow;

  // Shift, find any set bit among the top shamt bits, clamp to all-ones when saturating.
  always_comb begin
    shifted  = data_i << shamt_i;
    lostMask = ~({DATA_W{1'b1}} >> shamt_i);
    overflow = |(data_i & lostMask);
    result_o = shifted;
    sat_o    = 1'b0;
    if (mode_i && overflow) begin
      result_o = '1;
      sat_o    = 1'b1;
    end
  end

endmodule

// File: rtl/elastic_shift_fifo.sv
// Elastic shift FIFO: shifts words on entry, buffers them in a circular
// FIFO and presents them on a valid/ready initiator port.
module elastic_shift_fifo
  import elastic_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 4,
  parameter int SAT_MODE = SAT_MODE_TRUNC,
  localparam int SH_W    = $clog2(DATA_W),
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] t0_data,
  input  logic [SH_W-1:0]   t0_shamt,
  input  logic              t0_valid,
  output logic              t0_ready,
  output logic [DATA_W-1:0] i0_data,
  output logic              i0_sat,
  output logic              i0_valid,
  input  logic              i0_ready,
  input  logic              flush,
  output logic [CNT_W-1:0]  count
);

  localparam int AW = clog2_min1(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic SAT_EN = (SAT_MODE == SAT_MODE_SAT);

  logic [DATA_W-1:0] dataMem_q [DEPTH];
  logic              satMem_q  [DEPTH];
  logic [PW-1:0]     wr_q, wr_d;
  logic [PW-1:0]     rd_q, rd_d;
  logic              ready_q, ready_d;
  logic [DATA_W-1:0] shResult;
  logic              shSat;
  logic              push;
  logic              pop;
  logic [PW-1:0]     occupancy;

  elastic_shifter #(
    .DATA_W (DATA_W)
  ) u_shifter (
    .data_i   (t0_data),
    .shamt_i  (t0_shamt),
    .mode_i   (SAT_EN),
    .result_o (shResult),
    .sat_o    (shSat)
  );

  assign push      = t0_valid && ready_q;
  assign pop       = i0_valid && i0_ready;
  assign t0_ready  = ready_q;
  assign i0_valid  = (wr_q != rd_q);
  assign i0_data   = dataMem_q[rd_q[AW-1:0]];
  assign i0_sat    = satMem_q[rd_q[AW-1:0]];
  assign occupancy = wr_q - rd_q;
  assign count     = CNT_W'(occupancy);

  // Next pointers with flush taking priority; ready is precomputed from the next occupancy.
  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (flush) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (push) wr_d = wr_q + PTR_ONE;
      if (pop)  rd_d = rd_q + PTR_ONE;
    end
    ready_d = !((wr_d[AW] != rd_d[AW]) && (wr_d[AW-1:0] == rd_d[AW-1:0]));
  end

  // Pointer and ready registers; ready stays low while reset is held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      ready_q <= 1'b0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      ready_q <= ready_d;
    end
  end

  // Storage array; a word arriving during flush is never written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        dataMem_q[i] <= '0;
        satMem_q[i]  <= 1'b0;
      end
    end else if (push && !flush) begin
      dataMem_q[wr_q[AW-1:0]] <= shResult;
      satMem_q[wr_q[AW-1:0]]  <= shSat;
    end
  end

endmodule
